// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: scanned 7-segment bus to 6-digit frame decoder (SEG_HEX_EN accepts A-F patterns)
module seg_scan_decoder #(
  parameter int HOLD_MIN = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sel,
  input  logic [7:0]  led,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic        frame_valid,
  output logic        err
);
  typedef enum logic [1:0] {SYNC, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [5:0] prev_sel, lo;
  logic [7:0] cnt;
  logic [8:0] run;
  logic [19:0] tcnt;
  logic [2:0] idx, exp_idx, exp_n;
  logic [3:0] nib;
  logic [23:0] cap_digits, cap_n;
  logic [5:0] cap_dp, cap_dp_n;
  logic bad_pat, acc, multi, tmo, store, restart;
  logic frame_bad, frame_bad_n, err_n;
  always_comb begin
    nib = 4'hF;
    bad_pat = 1'b0;
    case (led[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
`ifdef SEG_HEX_EN
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
`endif
      default: bad_pat = 1'b1;
    endcase
  end
  assign lo = ~sel;
  assign multi = (lo & (lo - 6'd1)) != 6'd0;
  assign run = (sel == prev_sel) ? {1'b0, cnt} + 9'd1 : 9'd1;
  assign acc = run == 9'(HOLD_MIN) && sel != 6'h3F;
  assign tmo = state == CAPTURE && tcnt == 20'(TIMEOUT - 1) && !acc;
  always_comb begin
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) if (lo[i]) idx = 3'(i);
  end
  always_comb begin
    state_n = state == DONE ? SYNC : state;
    exp_n = exp_idx;
    cap_n = cap_digits;
    cap_dp_n = cap_dp;
    frame_bad_n = frame_bad;
    err_n = (state == DONE && !frame_bad) ? 1'b0 : err;
    store = 1'b0;
    restart = 1'b0;
    if (acc) begin
      if (multi) begin
        err_n = 1'b1;
        state_n = SYNC;
      end else if (state == CAPTURE && idx == exp_idx) begin
        store = 1'b1;
      end else if (idx == 3'd0) begin
        restart = 1'b1;
        err_n = err_n | (state == CAPTURE);
      end else if (state == CAPTURE) begin
        err_n = 1'b1;
        state_n = SYNC;
      end
    end else if (tmo) begin
      err_n = 1'b1;
      state_n = SYNC;
    end
    if (store || restart) begin
      for (int i = 0; i < 6; i++) begin
        if (3'(i) == idx) begin
          cap_n[4*i +: 4] = nib;
          cap_dp_n[i] = ~led[7];
        end
      end
      frame_bad_n = bad_pat | (store & frame_bad);
      exp_n = idx + 3'd1;
      state_n = idx == 3'd5 ? DONE : CAPTURE;
      err_n = err_n | bad_pat;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
      prev_sel <= 6'h3F;
      cnt <= 8'd0;
      tcnt <= 20'd0;
      exp_idx <= 3'd0;
      cap_digits <= 24'h0;
      cap_dp <= 6'h0;
      frame_bad <= 1'b0;
      digits <= 24'h0;
      dp <= 6'h0;
      frame_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      prev_sel <= sel;
      cnt <= run[8] ? 8'hFF : run[7:0];
      tcnt <= acc ? 20'd0 : (tcnt == 20'(TIMEOUT) ? tcnt : tcnt + 20'd1);
      exp_idx <= exp_n;
      cap_digits <= cap_n;
      cap_dp <= cap_dp_n;
      frame_bad <= frame_bad_n;
      frame_valid <= state == DONE;
      digits <= state == DONE ? cap_digits : digits;
      dp <= state == DONE ? cap_dp : dp;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized checks of seg_scan_decoder against a frame-level model
module tb_seg_scan_decoder;
  localparam int HOLD = 4;
  localparam int TMO = 16;
`ifdef SEG_HEX_EN
  localparam int NPAT = 16;
  localparam logic ERR_AFTER_F = 1'b0;
`else
  localparam int NPAT = 10;
  localparam logic ERR_AFTER_F = 1'b1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] sel = 6'h3F;
  logic [7:0] led = 8'hFF;
  logic [23:0] digits;
  logic [5:0] dp;
  logic frame_valid, err;
  int total = 0;
  int bad = 0;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [5:0] hist [$];
  int expect_d = -1;
  int idle = 0;
  logic [3:0] cap_d [6];
  logic cap_p [6];
  logic fbad = 1'b0;
  logic chk_en = 1'b0;
  logic [23:0] m_digits = 24'h0;
  logic [5:0] m_dp = 6'h0;
  logic m_fv = 1'b0;
  logic m_err = 1'b0;
  seg_scan_decoder #(.HOLD_MIN(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .led(led),
    .digits(digits), .dp(dp), .frame_valid(frame_valid), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] dsel(input int i);
    return ~(6'd1 << i);
  endfunction
  function automatic logic [7:0] ld(input int i, input logic on);
    return {~on, pat[i]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic model_step(input logic r, input logic [5:0] s, input logic [7:0] l);
    logic a;
    logic [5:0] low;
    int d;
    logic [3:0] nib;
    logic inval;
    m_fv = 1'b0;
    if (r) begin
      hist.delete();
      expect_d = -1;
      idle = 0;
      fbad = 1'b0;
      m_digits = 24'h0;
      m_dp = 6'h0;
      m_err = 1'b0;
      chk_en = 1'b1;
      return;
    end
    hist.push_back(s);
    if (hist.size() > HOLD + 1) void'(hist.pop_front());
    a = s != 6'h3F && hist.size() >= HOLD;
    for (int i = 0; i < HOLD; i++) if (a && hist[hist.size() - 1 - i] != s) a = 1'b0;
    if (hist.size() == HOLD + 1 && hist[0] == s) a = 1'b0;
    if (expect_d == 6) begin
      for (int i = 0; i < 6; i++) begin
        m_digits[4*i +: 4] = cap_d[i];
        m_dp[i] = cap_p[i];
      end
      m_fv = 1'b1;
      if (!fbad) m_err = 1'b0;
      expect_d = -1;
    end
    if (!a) begin
      idle++;
      if (expect_d >= 1 && expect_d <= 5 && idle == TMO) begin
        m_err = 1'b1;
        expect_d = -1;
      end
      return;
    end
    idle = 0;
    low = ~s;
    if ($countones(low) > 1) begin
      m_err = 1'b1;
      expect_d = -1;
      return;
    end
    d = 0;
    for (int i = 0; i < 6; i++) if (low[i]) d = i;
    if (!(expect_d >= 1 && d == expect_d)) begin
      if (d != 0) begin
        if (expect_d >= 1) begin
          m_err = 1'b1;
          expect_d = -1;
        end
        return;
      end
      if (expect_d >= 1) m_err = 1'b1;
      fbad = 1'b0;
    end
    nib = 4'hF;
    inval = 1'b1;
    for (int i = 0; i < NPAT; i++) begin
      if (l[6:0] == pat[i]) begin
        nib = 4'(i);
        inval = 1'b0;
      end
    end
    cap_d[d] = nib;
    cap_p[d] = ~l[7];
    if (inval) begin
      fbad = 1'b1;
      m_err = 1'b1;
    end
    expect_d = d + 1;
  endtask
  task automatic cyc(input logic r, input logic [5:0] s, input logic [7:0] l);
    @(negedge clk);
    rst = r;
    sel = s;
    led = l;
    model_step(r, s, l);
    @(posedge clk);
  endtask
  task automatic seg(input int d, input logic [7:0] l, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, dsel(d), l);
  endtask
  task automatic blank(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 6'h3F, 8'hFF);
  endtask
  task automatic frame(input logic [7:0] l5);
    for (int d = 0; d < 5; d++) seg(d, ld(d, 1'b0), 6);
    seg(5, l5, 6);
  endtask
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_digits", 32'(digits), 32'(m_digits));
      check("model_dp", 32'(dp), 32'(m_dp));
      check("model_frame_valid", 32'(frame_valid), 32'(m_fv));
      check("model_err", 32'(err), 32'(m_err));
    end
  end
  initial begin
    logic [5:0] s;
    logic [7:0] l;
    int r, len, g;
    cyc(1'b1, 6'h3F, 8'hFF);
    cyc(1'b1, 6'h3F, 8'hFF);
    #2;
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_fv_err", 32'({frame_valid, err}), 32'h0);
    for (int d = 0; d < 5; d++) seg(d, ld(d, 1'b0), 6);
    seg(5, 8'h92, 4);
    #2 check("basic_fv_early", 32'(frame_valid), 32'h0);
    seg(5, 8'h92, 1);
    #2;
    check("basic_fv", 32'(frame_valid), 32'h1);
    check("basic_digits", 32'(digits), 32'h543210);
    check("basic_dp_err", 32'({dp, err}), 32'h0);
    seg(5, 8'h92, 1);
    #2 check("basic_fv_once", 32'(frame_valid), 32'h0);
    seg(0, ld(0, 1'b0), 6);
    seg(1, ld(1, 1'b0), 6);
    seg(2, ld(2, 1'b0), 3);
    blank(2);
    #2 check("glitch_err", 32'(err), 32'h0);
    for (int d = 2; d < 6; d++) seg(d, ld(d, 1'b0), 6);
    #2 check("glitch_digits_err", 32'({digits, err}), 32'({24'h543210, 1'b0}));
    for (int k = 0; k < 4; k++) cyc(1'b0, 6'b111100, ld(0, 1'b0));
    #2 check("multi_err", 32'(err), 32'h1);
    check("multi_digits", 32'(digits), 32'h543210);
    blank(2);
    seg(0, ld(0, 1'b0), 6);
    seg(1, ld(1, 1'b0), 6);
    seg(3, ld(3, 1'b0), 4);
    #2 check("order_err", 32'(err), 32'h1);
    seg(3, ld(3, 1'b0), 2);
    frame(8'h8E);
    #2 check("hexf_digits", 32'(digits), 32'hF43210);
    check("hexf_err", 32'(err), 32'(ERR_AFTER_F));
    frame(8'h92);
    #2 check("clean_err", 32'(err), 32'h0);
    seg(0, ld(0, 1'b0), 6);
    seg(1, ld(1, 1'b0), 6);
    blank(13);
    #2 check("timeout_early", 32'(err), 32'h0);
    blank(1);
    #2 check("timeout_err", 32'(err), 32'h1);
    blank(6);
    frame(8'h92);
    #2 check("timeout_recover", 32'({digits, err}), 32'({24'h543210, 1'b0}));
    for (int d = 0; d < 4; d++) seg(d, ld(d, 1'b0), 6);
    cyc(1'b1, 6'h3F, 8'hFF);
    #2 check("midreset_outputs", 32'({digits, dp, frame_valid, err}), 32'h0);
    for (int d = 0; d < 4; d++) seg(d, ld(d, 1'b0), 6);
    seg(4, ld(4, 1'b1), 6);
    seg(5, 8'h92, 6);
    #2 check("dp4", 32'(dp), 32'b010000);
    check("dp4_digits", 32'(digits), 32'h543210);
    g = 0;
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 8);
      l = ld($urandom_range(0, 15), $urandom_range(0, 9) == 0);
      if (r < 2) begin
        cyc(1'b1, 6'h3F, 8'hFF);
        g = 0;
        continue;
      end
      if (r < 60) begin
        s = dsel(g);
        g = (g + 1) % 6;
      end else if (r < 75) begin
        s = dsel($urandom_range(0, 5));
      end else if (r < 85) begin
        s = 6'h3F;
        if (r < 80) len = $urandom_range(1, 20);
      end else if (r < 92) begin
        s = 6'($urandom);
      end else begin
        s = dsel(g);
        l = 8'($urandom);
      end
      for (int k = 0; k < len; k++) cyc(1'b0, s, l);
    end
    blank(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
